// File: rtl/tlb_ram_unit.sv
// rtl/tlb_ram_unit.sv - TLB entry register file, one sync write port, two async read ports
module tlb_ram_unit #(
    parameter int ENTRIES    = 8,
    parameter int ADR_WIDTH  = 3,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wEnable,
    input  logic [0:ADR_WIDTH-1]  writeAdr,
    input  logic [0:DATA_WIDTH-1] dataIn,
    input  logic [0:ADR_WIDTH-1]  readAdrA,
    output logic [0:DATA_WIDTH-1] dataOutA,
    input  logic [0:ADR_WIDTH-1]  readAdrB,
    output logic [0:DATA_WIDTH-1] dataOutB
);

    // One extra bit so that ENTRIES == 2^ADR_WIDTH is representable for the range checks.
    localparam logic [ADR_WIDTH:0] ENTRIES_W = ENTRIES[ADR_WIDTH:0];

    logic [0:DATA_WIDTH-1] entry [0:ENTRIES-1];

    logic writeInRange;
    logic readInRangeA;
    logic readInRangeB;

    assign writeInRange = ({1'b0, writeAdr} < ENTRIES_W);
    assign readInRangeA = ({1'b0, readAdrA} < ENTRIES_W);
    assign readInRangeB = ({1'b0, readAdrB} < ENTRIES_W);

    // Storage update: reset clears every entry at once and overrides any write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry[i] <= '0;
            end
        end else if (wEnable && writeInRange) begin
            entry[writeAdr] <= dataIn;
        end
    end

    // Combinational read ports: no bypass, out-of-range indices read as zero.
    always_comb begin
        dataOutA = '0;
        dataOutB = '0;
        if (readInRangeA) begin
            dataOutA = entry[readAdrA];
        end
        if (readInRangeB) begin
            dataOutB = entry[readAdrB];
        end
    end

endmodule

// File: tb/tb_tlb_ram_unit.sv
// tb/tb_tlb_ram_unit.sv - directed table-driven bench for tlb_ram_unit
module tb_tlb_ram_unit;

    logic        clk;
    logic        rst;
    logic        wEnable;
    logic [0:2]  writeAdr;
    logic [0:47] dataIn;
    logic [0:2]  readAdrA;
    logic [0:47] dataOutA;
    logic [0:2]  readAdrB;
    logic [0:47] dataOutB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [0:2]  wa;
        logic [0:47] din;
        logic [0:2]  ra;
        logic [0:2]  rb;
        logic [0:47] ea;
        logic [0:47] eb;
    } vec_t;

    vec_t vecs[$];

    tlb_ram_unit #(
        .ENTRIES(8),
        .ADR_WIDTH(3),
        .DATA_WIDTH(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wEnable(wEnable),
        .writeAdr(writeAdr),
        .dataIn(dataIn),
        .readAdrA(readAdrA),
        .dataOutA(dataOutA),
        .readAdrB(readAdrB),
        .dataOutB(dataOutB)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [0:47] act, input logic [0:47] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic we, input logic [0:2] wa, input logic [0:47] din,
                          input logic [0:2] ra, input logic [0:2] rb,
                          input logic [0:47] ea, input logic [0:47] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.din = din;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        vecs.push_back(v);
    endtask

    // Drive each vector on a falling edge, sample 1 time unit after the following rising edge.
    task automatic runVecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            wEnable  = vecs[i].we;
            writeAdr = vecs[i].wa;
            dataIn   = vecs[i].din;
            readAdrA = vecs[i].ra;
            readAdrB = vecs[i].rb;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_A", i), dataOutA, vecs[i].ea);
            check($sformatf("vec%0d_B", i), dataOutB, vecs[i].eb);
        end
    endtask

    function automatic logic [0:47] sweepVal(input int a);
        logic [0:2] aa;
        aa = a[2:0];
        return {16'hCAFE, 29'h0, aa};
    endfunction

    initial begin
        int firstSweep;
        int lastSweep;
        logic [0:2] aa;

        rst      = 1'b1;
        wEnable  = 1'b0;
        writeAdr = 3'd0;
        dataIn   = '0;
        readAdrA = 3'd0;
        readAdrB = 3'd7;

        // Basic write/read and write-disable vectors
        addVec(1'b1, 3'd0, 48'h001200120034, 3'd0, 3'd1, 48'h001200120034, 48'h000000000000);
        addVec(1'b1, 3'd2, 48'h120012003400, 3'd0, 3'd1, 48'h001200120034, 48'h000000000000);
        addVec(1'b0, 3'd0, 48'h000000000000, 3'd2, 3'd2, 48'h120012003400, 48'h120012003400);
        for (int k = 0; k < 3; k++) begin
            addVec(1'b0, 3'd0, 48'hFFFFFFFFFFFF, 3'd0, 3'd2, 48'h001200120034, 48'h120012003400);
        end
        // Sweep: write every address, port B watches entry 0
        firstSweep = vecs.size();
        for (int a = 0; a < 8; a++) begin
            aa = a[2:0];
            addVec(1'b1, aa, sweepVal(a), aa, 3'd0, sweepVal(a), sweepVal(0));
        end
        addVec(1'b1, 3'd7, 48'h0, 3'd7, 3'd6, 48'h0, sweepVal(6));
        for (int a = 0; a < 7; a++) begin
            aa = a[2:0];
            addVec(1'b0, 3'd0, 48'h0, aa, 3'd7, sweepVal(a), 48'h0);
        end
        lastSweep = vecs.size() - 1;

        // Asynchronous reset at t=5, away from any rising edge
        #5;
        rst = 1'b0;
        #1;
        check("reset_A", dataOutA, 48'h0);
        check("reset_B", dataOutB, 48'h0);
        @(negedge clk);
        rst = 1'b1;

        runVecs(0, firstSweep - 1);

        // Read-during-write on entry 3: old value before the edge, new value after
        @(negedge clk);
        wEnable  = 1'b1;
        writeAdr = 3'd3;
        dataIn   = 48'hAAAA5555AAAA;
        readAdrA = 3'd3;
        readAdrB = 3'd3;
        #1;
        check("rdw_before_A", dataOutA, 48'h0);
        check("rdw_before_B", dataOutB, 48'h0);
        @(posedge clk);
        #1;
        check("rdw_after_A", dataOutA, 48'hAAAA5555AAAA);
        check("rdw_after_B", dataOutB, 48'hAAAA5555AAAA);
        @(negedge clk);
        wEnable = 1'b0;

        runVecs(firstSweep, lastSweep);

        // Reset mid-operation with a write pending
        @(negedge clk);
        wEnable  = 1'b1;
        writeAdr = 3'd1;
        dataIn   = 48'hFFFFFFFFFFFF;
        readAdrA = 3'd0;
        readAdrB = 3'd1;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_A", dataOutA, 48'h0);
        check("midrst_B", dataOutB, 48'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rsthold%0d_A", k), dataOutA, 48'h0);
            check($sformatf("rsthold%0d_B", k), dataOutB, 48'h0);
        end
        @(negedge clk);
        wEnable = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        wEnable  = 1'b1;
        writeAdr = 3'd5;
        dataIn   = 48'h123456789ABC;
        readAdrA = 3'd5;
        @(posedge clk);
        #1;
        check("postrst_wr5", dataOutA, 48'h123456789ABC);
        @(negedge clk);
        wEnable = 1'b0;
        for (int a = 0; a < 8; a++) begin
            readAdrA = a[2:0];
            readAdrB = a[2:0];
            #1;
            check($sformatf("postrst_a%0d_A", a), dataOutA, (a == 5) ? 48'h123456789ABC : 48'h0);
            check($sformatf("postrst_a%0d_B", a), dataOutB, (a == 5) ? 48'h123456789ABC : 48'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
